// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with TX FIFO
module uart_tx_buffered #(
    parameter int CLOCK_HZ   = 80000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Valid,
    input  logic [7:0]                    i_Data,
    output logic                          o_Ready,
    output logic                          o_TX,
    output logic                          o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Overflow
);

    localparam int DIVIDER  = CLOCK_HZ / BAUD;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int STOP_LEN = STOP_BITS * DIVIDER;
    localparam int CW       = $clog2(STOP_LEN);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shift_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            tx_q, tx_nxt, busy_q, overflow_q;
    logic            push, pop, not_empty, bit_done, stop_done;

    assign o_Ready    = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = i_Valid && o_Ready;
    assign not_empty  = (count != '0);
    assign bit_done   = (baud_cnt == CW'(DIVIDER - 1));
    assign stop_done  = (baud_cnt == CW'(STOP_LEN - 1));
    assign o_TX       = tx_q;
    assign o_Busy     = busy_q;
    assign o_Count    = count;
    assign o_Overflow = overflow_q;

    // tx_nxt is decoded from the current state and registered, so the line lags the FSM by one clock
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + CW'(1);
        bit_nxt   = bit_idx;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (not_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_nxt = shift_q[bit_idx];
                if (bit_done) begin
                    baud_nxt = '0;
                    bit_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (stop_done) begin
                    baud_nxt = '0;
                    if (not_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_n && push) mem[wr_ptr] <= i_Data;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            tx_q     <= tx_nxt;
            busy_q   <= (state != IDLE) || not_empty;
            if (i_Valid && !o_Ready) overflow_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                shift_q <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
